// File: rtl/srm_pkg.sv
// Shared ISA constants, instruction fields, controller states and the
// per-state control-word table for the Simple RISC Machine controller.
package srm_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [3:0] VSEL_MDATA = 4'b0001;
  localparam logic [3:0] VSEL_IMM8  = 4'b0010;
  localparam logic [3:0] VSEL_PC    = 4'b0100;
  localparam logic [3:0] VSEL_C     = 4'b1000;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_MOV_IMM, C_MOV_REG, C_ADD_AND, C_CMP, C_MVN
  } iclass_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } fields_t;

  typedef struct packed {
    logic       w;
    logic       write;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] shift;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore output table: the control word a state presents while it is current.
  function automatic ctrl_t ctrl_for(state_t st, fields_t f, iclass_t c);
    ctrl_t o;
    o      = '0;
    o.vsel = VSEL_C;
    case (st)
      S_WAIT:      o.w = 1'b1;
      S_WRITE_IMM: begin
        o.writenum = f.rn;
        o.vsel     = VSEL_IMM8;
        o.write    = 1'b1;
      end
      S_GET_A: begin
        o.readnum = f.rn;
        o.loada   = 1'b1;
      end
      S_GET_B: begin
        o.readnum = f.rm;
        o.loadb   = 1'b1;
        o.shift   = f.sh;
        o.alu_op  = f.op;
      end
      S_EXEC: begin
        o.shift  = f.sh;
        o.alu_op = f.op;
        o.asel   = (c == C_MOV_REG);
        o.loads  = (c == C_CMP);
        o.loadc  = (c != C_CMP);
      end
      S_WRITE_REG: begin
        o.writenum = f.rd;
        o.write    = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> fetch/datapath bundle. master = controller, slave = the
// harness/datapath side. state and ir are debug observation points.
interface cpu_controller_if;
  import srm_pkg::*;

  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  state_t      state;
  logic [15:0] ir;

  modport master (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5, state, ir
  );

  modport slave (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5, state, ir
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational IR decode: field split, immediate sign extension and
// instruction class used by the sequencing FSM.
module instr_decoder
  import srm_pkg::*;
(
  input  logic [15:0] ir,
  output fields_t     f,
  output iclass_t     cls,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign f.opcode = ir[OPC_LSB +: 3];
  assign f.op     = ir[OP_LSB  +: 2];
  assign f.rn     = ir[RN_LSB  +: 3];
  assign f.rd     = ir[RD_LSB  +: 3];
  assign f.sh     = ir[SH_LSB  +: 2];
  assign f.rm     = ir[RM_LSB  +: 3];

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    cls = C_NOP;
    if (f.opcode == OPC_MOV) begin
      if (f.op == OP_MOV_IMM)      cls = C_MOV_IMM;
      else if (f.op == OP_MOV_REG) cls = C_MOV_REG;
    end else if (f.opcode == OPC_ALU) begin
      case (f.op)
        OP_CMP:  cls = C_CMP;
        OP_MVN:  cls = C_MVN;
        default: cls = C_ADD_AND;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Simple RISC Machine sequencing controller: instruction register plus a
// Moore FSM whose control outputs are registered alongside the state.
module cpu_controller
  import srm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.master bus
);

  state_t      state, nxt;
  logic [15:0] ir;
  ctrl_t       ctrl_q;
  fields_t     f;
  iclass_t     cls;

  instr_decoder u_dec (
    .ir     (ir),
    .f      (f),
    .cls    (cls),
    .sximm8 (bus.sximm8),
    .sximm5 (bus.sximm5)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT:   if (bus.s) nxt = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_MOV_IMM:         nxt = S_WRITE_IMM;
          C_MOV_REG, C_MVN:  nxt = S_GET_B;
          C_ADD_AND, C_CMP:  nxt = S_GET_A;
          default:           nxt = S_WAIT;
        endcase
      end
      S_GET_A:     nxt = S_GET_B;
      S_GET_B:     nxt = S_EXEC;
      S_EXEC:      nxt = (cls == C_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_IMM: nxt = S_WAIT;
      S_WRITE_REG: nxt = S_WAIT;
      default:     nxt = S_WAIT;
    endcase
  end

  // Outputs are computed for the state being entered, so they switch on the
  // same edge as the state. The IR only changes on the WAIT->DECODE edge,
  // and DECODE's control word does not depend on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_WAIT;
      ir     <= '0;
      ctrl_q <= ctrl_for(S_WAIT, '0, C_NOP);
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_for(nxt, f, cls);
      if (state == S_WAIT && bus.load) ir <= bus.in;
    end
  end

  assign bus.w        = ctrl_q.w;
  assign bus.write    = ctrl_q.write;
  assign bus.vsel     = ctrl_q.vsel;
  assign bus.loada    = ctrl_q.loada;
  assign bus.loadb    = ctrl_q.loadb;
  assign bus.loadc    = ctrl_q.loadc;
  assign bus.loads    = ctrl_q.loads;
  assign bus.asel     = ctrl_q.asel;
  assign bus.bsel     = ctrl_q.bsel;
  assign bus.readnum  = ctrl_q.readnum;
  assign bus.writenum = ctrl_q.writenum;
  assign bus.shift    = ctrl_q.shift;
  assign bus.ALUop    = ctrl_q.alu_op;
  assign bus.state    = state;
  assign bus.ir       = ir;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Sequencing controller for the Simple RISC Machine datapath. It holds the instruction register, decodes the current instruction, and steps a Moore state machine that drives every datapath control input: register-file read/write numbers, load strobes, operand selects, shift, ALU op, writeback select and the sign-extended immediates. It sits between instruction fetch/test harness (`in`, `load`, `s`) and the datapath; `w` reports idle.

## Interface
Parameters:
- none; widths fixed by ISA (16-bit instruction, 8 registers).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces state WAIT, IR = 0.
- `in` in 16: instruction word.
- `load` in 1: IR load enable, honoured only in WAIT.
- `s` in 1: start, level-sampled in WAIT only.
- `w` out 1: 1 when in WAIT.
- `readnum` out 3 / `writenum` out 3: register numbers to regfile.
- `write` out 1: regfile write strobe.
- `vsel` out 4: one-hot writeback select (0001 mdata, 0010 sximm8, 0100 PC, 1000 C).
- `loada`, `loadb`, `loadc`, `loads` out 1 each: datapath register loads.
- `asel`, `bsel` out 1 each: operand selects (asel=1 → A=0; bsel=1 → sximm5).
- `shift` out 2, `ALUop` out 2.
- `sximm8` out 16, `sximm5` out 16: sign-extended IR[7:0], IR[4:0].

## Operation
- IR fields: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0], imm5 [4:0].
- Supported: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. Anything else: no-op.
- States and outputs (all unlisted strobes 0, vsel=1000, asel=bsel=0, shift=00, readnum=writenum=0):
  - WAIT: w=1. `s`=1 → DECODE.
  - DECODE: MOV imm → WRITE_IMM; MOV reg, MVN → GET_B; ADD/CMP/AND → GET_A; undefined → WAIT.
  - WRITE_IMM: writenum=Rn, vsel=0010, write=1 → WAIT.
  - GET_A: readnum=Rn, loada=1 → GET_B.
  - GET_B: readnum=Rm, loadb=1 → EXEC.
  - EXEC: shift=sh, ALUop=op, bsel=0; asel=1 for MOV reg else 0; CMP: loads=1, loadc=0 → WAIT; others: loadc=1 → WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=1000, write=1 → WAIT.
- `shift` = sh also during GET_B (stable before EXEC); ALUop = op in GET_B and EXEC.
- sximm8/sximm5 are combinational from IR, valid in every state.

## Timing
- Reset (async): state WAIT, IR=0x0000, w=1, all strobes 0, sximm8=sximm5=0 — effective immediately, not at next edge.
- Latency from edge sampling `s`=1 in WAIT to w=1: MOV imm 3 cycles; MOV reg/MVN 5; ADD/AND 6; CMP 5; undefined 2.
- `load` and `s` both 1 in WAIT: IR and state update on the same edge; DECODE uses the new IR.
- `load` outside WAIT ignored; IR stable throughout an instruction.
- `s` held high: instruction re-executes on each return to WAIT (level semantics, no edge detect).
- Reset mid-instruction: abandon at once, no further strobes; partially loaded A/B/C in datapath left as-is.
- Exactly one of write/loada/loadb/loadc/loads asserted per cycle (or none).

## Structure
- Package `srm_pkg`: opcode/op constants, state enum, vsel one-hot constants, IR field positions.
- Sub-module `instr_decoder` (combinational): IR → fields, sign extension, instruction class; FSM and IR live in `cpu_controller`.

## Test plan
- Assert reset mid-cycle → w=1, write/load*=0, IR=0 without a clock edge.
- Load 0xD007, s=1 → DECODE, then WRITE_IMM with writenum=0, vsel=0010, write=1, sximm8=0x0007; w=1 on 3rd cycle.
- Load 0xD1FE (MOV R1,#-2) → sximm8=0xFFFE, writenum=1, write one cycle.
- Load 0xA148 (ADD R2,R1,R0,LSL#1) → GET_A readnum=1 loada; GET_B readnum=0 loadb shift=01; EXEC loadc ALUop=00 asel=0; WRITE_REG writenum=2 vsel=1000 write.
- Load 0xA900 (CMP R1,R0) → EXEC loads=1, loadc=0, write never asserted; 0x0000 → back to WAIT after DECODE, no strobes.
- Start ADD, assert reset in GET_B → WAIT immediately; pulse `load` with 0xD007 during EXEC → IR unchanged.
